// File: rtl/cskpa_add_sched.sv
// cskpa_add_sched: round-robin scheduler time-sharing one 64-bit carry-skip
// adder (carry-in 0) between two requesters.
//
// Optional feature macro: CSKPA_SCHED_OVF_EN adds rsp_ovf (registered signed
// overflow of the captured operands, same timing as rsp_sum).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[1:0]      per-requester request
//   req_ready[1:0]      per-requester accept strobe (combinational, one-hot or 0)
//   a0,b0 / a1,b1       64-bit operands of requester 0 / 1
//   rsp_valid/rsp_ready response handshake
//   rsp_id              owner of the current result
//   rsp_sum, rsp_cout   registered {cout,sum} = a + b
//   busy                high whenever the FSM is not idle
//   op_count            completed responses, wraps modulo 2^CNT_W
//   rsp_ovf             (CSKPA_SCHED_OVF_EN only) signed overflow flag

// 64-bit carry-skip adder: 4-bit ripple blocks, block carry bypassed when the
// whole block propagates.
module cskpa_add64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    localparam int unsigned DW    = 64;
    localparam int unsigned BLK_W = 4;
    localparam int unsigned NBLK  = DW / BLK_W;

    always_comb begin
        logic [NBLK:0] blk_c;
        logic          c;
        logic          p;
        logic          blk_p;
        sum      = '0;
        blk_c    = '0;
        blk_c[0] = cin;
        for (int unsigned k = 0; k < NBLK; k++) begin
            c     = blk_c[k];
            blk_p = 1'b1;
            for (int unsigned j = 0; j < BLK_W; j++) begin
                p                 = a[k*BLK_W+j] ^ b[k*BLK_W+j];
                sum[k*BLK_W+j]    = p ^ c;
                c                 = (a[k*BLK_W+j] & b[k*BLK_W+j]) | (p & c);
                blk_p             = blk_p & p;
            end
            // Skip path: a fully propagating block passes its carry-in through.
            blk_c[k+1] = blk_p ? blk_c[k] : c;
        end
        cout = blk_c[NBLK];
    end
endmodule

module cskpa_add_sched #(
    parameter int unsigned RR_INIT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [63:0]      a0,
    input  logic [63:0]      b0,
    input  logic [63:0]      a1,
    input  logic [63:0]      b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [63:0]      rsp_sum,
    output logic             rsp_cout,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
`ifdef CSKPA_SCHED_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);
    localparam int unsigned DW = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            prio_q;
    logic [DW-1:0]   op_a_q, op_b_q;
    logic            id_q;
    logic            winner;
    logic            accept;
    logic            handshake;
    logic [DW-1:0]   add_sum;
    logic            add_cout;

    cskpa_add64 u_add (
        .a    (op_a_q),
        .b    (op_b_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, arbitration and accept strobe.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        handshake = 1'b0;
        req_ready = 2'b00;
        // Lone requester wins; with both valid the priority holder wins.
        winner    = (req_valid == 2'b11) ? prio_q : req_valid[1];
        unique case (state_q)
            IDLE: begin
                // rst_n gating keeps req_ready low while reset is held.
                if ((req_valid != 2'b00) && rst_n) begin
                    accept    = 1'b1;
                    req_ready = winner ? 2'b10 : 2'b01;
                    state_d   = ADD;
                end
            end
            ADD: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, result registers, priority and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            id_q      <= 1'b0;
            prio_q    <= (RR_INIT != 0);
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            busy      <= 1'b0;
            op_count  <= '0;
`ifdef CSKPA_SCHED_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_a_q <= winner ? a1 : a0;
                op_b_q <= winner ? b1 : b0;
                id_q   <= winner;
                busy   <= 1'b1;
            end
            if (state_q == ADD) begin
                rsp_sum   <= add_sum;
                rsp_cout  <= add_cout;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
`ifdef CSKPA_SCHED_OVF_EN
                rsp_ovf   <= (op_a_q[DW-1] == op_b_q[DW-1]) &&
                             (add_sum[DW-1] != op_a_q[DW-1]);
`endif
            end
            if (handshake) begin
                rsp_valid <= 1'b0;
                busy      <= 1'b0;
                op_count  <= op_count + CNT_W'(1);
                prio_q    <= ~rsp_id;
            end
        end
    end
endmodule
